// File: rtl/int_context_saver_pkg.sv
// Shared definitions for the interrupt context saver: step codes from the
// interrupt controller, memory word width and the sequencer state encoding.
package int_context_saver_pkg;

  localparam int WORD_W = 16;

  localparam logic [3:0] IC_IDLE   = 4'b0000;
  localparam logic [3:0] IC_DRAIN  = 4'b0001;
  localparam logic [3:0] IC_SAVE   = 4'b0010;
  localparam logic [3:0] IC_VECTOR = 4'b0110;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_PUSH_PCH,
    ST_PUSH_PCL,
    ST_PUSH_FLG,
    ST_WAIT_VEC,
    ST_RD_VECH,
    ST_RD_VECL,
    ST_LOAD_PC
  } seq_state_t;

  function automatic logic step_is_legal(input logic [3:0] step);
    return (step == IC_IDLE) || (step == IC_DRAIN) ||
           (step == IC_SAVE) || (step == IC_VECTOR);
  endfunction

endpackage

// File: rtl/int_context_saver_fsm.sv
// Sequencer for the context save: state register, pending-vector flag and the
// sticky illegal-step flag. Memory stalls freeze the state in place.
module int_seq_fsm
  import int_context_saver_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ic_step,
  input  logic       mem_busy,
  output seq_state_t state,
  output logic       snap_en,
  output logic       seq_err
);

  seq_state_t state_q, state_d;
  logic       vec_pend_q, vec_pend_d;
  logic       seq_err_q, seq_err_d;
  logic       vec_seen;

  always_comb begin
    state_d    = state_q;
    vec_pend_d = vec_pend_q;
    seq_err_d  = seq_err_q;
    vec_seen   = (ic_step == IC_VECTOR);

    if (state_q != ST_IDLE && state_q != ST_DRAIN && !step_is_legal(ic_step)) begin
      seq_err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (ic_step == IC_DRAIN)     state_d = ST_DRAIN;
        else if (ic_step == IC_SAVE) state_d = ST_PUSH_PCH;
      end
      ST_DRAIN: begin
        if (ic_step == IC_SAVE)      state_d = ST_PUSH_PCH;
        else if (ic_step == IC_IDLE) state_d = ST_IDLE;
      end
      ST_PUSH_PCH: begin
        if (vec_seen)  vec_pend_d = 1'b1;
        if (!mem_busy) state_d = ST_PUSH_PCL;
      end
      ST_PUSH_PCL: begin
        if (vec_seen)  vec_pend_d = 1'b1;
        if (!mem_busy) state_d = ST_PUSH_FLG;
      end
      ST_PUSH_FLG: begin
        // A vector that arrived during the pushes skips the wait state.
        if (!mem_busy) begin
          state_d    = (vec_pend_q || vec_seen) ? ST_RD_VECH : ST_WAIT_VEC;
          vec_pend_d = 1'b0;
        end else if (vec_seen) begin
          vec_pend_d = 1'b1;
        end
      end
      ST_WAIT_VEC: begin
        if (vec_seen) state_d = ST_RD_VECH;
      end
      ST_RD_VECH: begin
        if (!mem_busy) state_d = ST_RD_VECL;
      end
      ST_RD_VECL: begin
        if (!mem_busy) state_d = ST_LOAD_PC;
      end
      ST_LOAD_PC: begin
        state_d    = ST_IDLE;
        vec_pend_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    snap_en = (state_d == ST_PUSH_PCH) && (state_q != ST_PUSH_PCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      vec_pend_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_pend_q <= vec_pend_d;
      seq_err_q  <= seq_err_d;
    end
  end

  assign state   = state_q;
  assign seq_err = seq_err_q;

endmodule

// File: rtl/int_context_saver.sv
// Turns interrupt-controller step codes into fetch stall, stack pushes of
// PC/flags and the two-word vector fetch that loads the ISR address into the PC.
module int_context_saver
  import int_context_saver_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] VEC_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        ic_step,
  input  logic [31:0]       pc_in,
  input  logic [3:0]        flags_in,
  input  logic [ADDR_W-1:0] sp_in,
  input  logic              mem_busy,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              stall_fetch,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              sp_we,
  output logic [ADDR_W-1:0] sp_out,
  output logic              pc_we,
  output logic [31:0]       pc_out,
  output logic              seq_done,
  output logic              seq_err
);

  seq_state_t        state;
  logic              snap_en;
  logic [31:0]       pc_snap_q, pc_snap_d;
  logic [3:0]        flg_snap_q, flg_snap_d;
  logic [ADDR_W-1:0] sp_snap_q, sp_snap_d;
  logic [WORD_W-1:0] vec_hi_q, vec_hi_d;
  logic              rd_acc_q, rd_acc_d;

  // Stack grows downward and wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] sp_sub(input logic [ADDR_W-1:0] sp,
                                               input int unsigned n);
    return sp - ADDR_W'(n);
  endfunction

  int_seq_fsm u_fsm (
    .clk      (clk),
    .rst      (rst),
    .ic_step  (ic_step),
    .mem_busy (mem_busy),
    .state    (state),
    .snap_en  (snap_en),
    .seq_err  (seq_err)
  );

  always_comb begin
    pc_snap_d  = pc_snap_q;
    flg_snap_d = flg_snap_q;
    sp_snap_d  = sp_snap_q;
    vec_hi_d   = vec_hi_q;
    if (snap_en) begin
      pc_snap_d  = pc_in;
      flg_snap_d = flags_in;
      sp_snap_d  = sp_in;
    end
    // Read data arrives the cycle after the read retires; grab the high word once.
    if (state == ST_RD_VECL && rd_acc_q) vec_hi_d = mem_rdata;
    rd_acc_d = (state == ST_RD_VECH || state == ST_RD_VECL) && !mem_busy;
  end

  always_comb begin
    stall_fetch = (state != ST_IDLE);
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    sp_we       = 1'b0;
    sp_out      = '0;
    pc_we       = 1'b0;
    pc_out      = '0;
    seq_done    = 1'b0;
    case (state)
      ST_PUSH_PCH: begin
        mem_we    = 1'b1;
        mem_addr  = sp_snap_q;
        mem_wdata = pc_snap_q[31:16];
      end
      ST_PUSH_PCL: begin
        mem_we    = 1'b1;
        mem_addr  = sp_sub(sp_snap_q, 1);
        mem_wdata = pc_snap_q[15:0];
      end
      ST_PUSH_FLG: begin
        mem_we    = 1'b1;
        mem_addr  = sp_sub(sp_snap_q, 2);
        mem_wdata = {{(WORD_W-4){1'b0}}, flg_snap_q};
        sp_we     = 1'b1;
        sp_out    = sp_sub(sp_snap_q, 3);
      end
      ST_RD_VECH: begin
        mem_re   = 1'b1;
        mem_addr = VEC_ADDR;
      end
      ST_RD_VECL: begin
        mem_re   = 1'b1;
        mem_addr = VEC_ADDR + ADDR_W'(1);
      end
      ST_LOAD_PC: begin
        pc_we    = 1'b1;
        pc_out   = {vec_hi_q, mem_rdata};
        seq_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) rd_acc_q <= 1'b0;
    else     rd_acc_q <= rd_acc_d;
  end

  always_ff @(posedge clk) begin
    pc_snap_q  <= pc_snap_d;
    flg_snap_q <= flg_snap_d;
    sp_snap_q  <= sp_snap_d;
    vec_hi_q   <= vec_hi_d;
  end

endmodule

// File: tb/tb_int_context_saver.sv
// Bench for int_context_saver: word memory model, directed table of sequences,
// hand-written reset cases and randomized runs against a stack/vector model.
module tb_int_context_saver;
  import int_context_saver_pkg::*;

  localparam logic [15:0] VEC = 16'h0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  ic_step;
  logic [31:0] pc_in;
  logic [3:0]  flags_in;
  logic [15:0] sp_in;
  logic        mem_busy;
  logic [15:0] mem_rdata;
  logic        stall_fetch, mem_we, mem_re, sp_we, pc_we, seq_done, seq_err;
  logic [15:0] mem_addr, mem_wdata, sp_out;
  logic [31:0] pc_out;

  logic        ld_req;
  logic [15:0] ld_hi, ld_lo;
  logic [15:0] mem [0:65535];

  int n_checks = 0;
  int n_err    = 0;

  int_context_saver #(.ADDR_W(16), .VEC_ADDR(VEC)) dut (
    .clk(clk), .rst(rst), .ic_step(ic_step), .pc_in(pc_in), .flags_in(flags_in),
    .sp_in(sp_in), .mem_busy(mem_busy), .mem_rdata(mem_rdata),
    .stall_fetch(stall_fetch), .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .sp_we(sp_we), .sp_out(sp_out), .pc_we(pc_we),
    .pc_out(pc_out), .seq_done(seq_done), .seq_err(seq_err)
  );

  // Word memory: accesses retire on a non-busy edge, read data one cycle later.
  always @(posedge clk) begin
    if (ld_req) begin
      mem[VEC]         <= ld_hi;
      mem[VEC + 16'd1] <= ld_lo;
    end else if (mem_we && !mem_busy) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_re && !mem_busy) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  flags;
    logic [15:0] sp, vhi, vlo;
    int          ndrain, vgap, busy_at, busy_len;
    bit          illegal;
    logic [31:0] exp_pc;
    logic [15:0] exp_sp, exp_a0, exp_a1, exp_a2, exp_flw;
    int          exp_wecyc, exp_a1cyc, exp_lat;
    bit          exp_err;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Stack image after the three pushes, then the ISR address read from the vector words.
  function automatic logic [31:0] model_vec(input logic [15:0] sp, input logic [31:0] pc,
                                            input logic [3:0] fl, input logic [15:0] vhi,
                                            input logic [15:0] vlo);
    logic [15:0] m [int];
    logic [15:0] a1, a2;
    a1 = sp - 16'd1;
    a2 = sp - 16'd2;
    m[int'(VEC)]         = vhi;
    m[int'(VEC + 16'd1)] = vlo;
    m[int'(sp)]          = pc[31:16];
    m[int'(a1)]          = pc[15:0];
    m[int'(a2)]          = {12'h000, fl};
    return {m[int'(VEC)], m[int'(VEC + 16'd1)]};
  endfunction

  task automatic run_seq(input vec_t v, input string tag);
    logic [15:0] wa[$];
    logic [15:0] wd[$];
    logic [15:0] sp_o = '0;
    logic [31:0] pc_o = '0;
    logic        bsy;
    int wecyc = 0, a1cyc = 0, spwe = 0, pcwe = 0, done = 0;
    int rd_early = 0, nostall = 0, pc_it = -1, after = 0;
    @(negedge clk);
    ic_step = IC_IDLE; mem_busy = 1'b0;
    ld_hi = v.vhi; ld_lo = v.vlo; ld_req = 1'b1;
    pc_in = v.pc; flags_in = v.flags; sp_in = v.sp;
    for (int i = 0; i < v.ndrain; i++) begin
      @(negedge clk);
      ld_req = 1'b0; ic_step = IC_DRAIN;
    end
    for (int cyc = 0; cyc < 80 && after < 3; cyc++) begin
      @(negedge clk);
      ld_req = 1'b0;
      bsy = (v.busy_at != 0) && (cyc >= v.busy_at) && (cyc < v.busy_at + v.busy_len);
      if ((cyc > 0 || v.ndrain > 0) && done == 0 && !stall_fetch) nostall++;
      if (mem_we) begin
        wecyc++;
        if (mem_addr == v.exp_a1) a1cyc++;
      end
      if (mem_we && !bsy) begin
        wa.push_back(mem_addr);
        wd.push_back(mem_wdata);
      end
      if (mem_re && !bsy && wa.size() < 3) rd_early++;
      if (sp_we && !bsy) begin spwe++; sp_o = sp_out; end
      if (pc_we) begin pcwe++; pc_o = pc_out; pc_it = cyc; end
      if (seq_done) done++;
      if (done > 0) after++;
      mem_busy = bsy;
      if (cyc == 0)                             ic_step = IC_SAVE;
      else if (done > 0)                        ic_step = IC_IDLE;
      else if (cyc == v.vgap)                   ic_step = IC_VECTOR;
      else if (v.illegal && cyc == v.vgap - 1)  ic_step = 4'b1111;
      else                                      ic_step = 4'($urandom_range(0, 1));
      if (cyc > 0) begin
        pc_in = $urandom; flags_in = 4'($urandom); sp_in = 16'($urandom);
      end
    end
    ic_step = IC_IDLE; mem_busy = 1'b0;
    check({tag, "_nwr"}, 64'(wa.size()), 64'd3);
    if (wa.size() >= 3) begin
      check({tag, "_wr0"}, {wa[0], wd[0]}, {v.exp_a0, v.pc[31:16]});
      check({tag, "_wr1"}, {wa[1], wd[1]}, {v.exp_a1, v.pc[15:0]});
      check({tag, "_wr2"}, {wa[2], wd[2]}, {v.exp_a2, v.exp_flw});
    end
    check({tag, "_rd_early"}, 64'(rd_early), 64'd0);
    check({tag, "_spwe_cnt"}, 64'(spwe), 64'd1);
    check({tag, "_sp_out"}, 64'(sp_o), 64'(v.exp_sp));
    check({tag, "_pcwe_cnt"}, 64'(pcwe), 64'd1);
    check({tag, "_pc_out"}, 64'(pc_o), 64'(v.exp_pc));
    check({tag, "_done_cnt"}, 64'(done), 64'd1);
    check({tag, "_stall_gap"}, 64'(nostall), 64'd0);
    check({tag, "_seq_err"}, 64'(seq_err), 64'(v.exp_err));
    check({tag, "_idle_after"}, 64'(stall_fetch), 64'd0);
    if (v.exp_wecyc >= 0) check({tag, "_we_cycles"}, 64'(wecyc), 64'(v.exp_wecyc));
    if (v.exp_a1cyc >= 0) check({tag, "_pcl_hold"}, 64'(a1cyc), 64'(v.exp_a1cyc));
    if (v.exp_lat >= 0)   check({tag, "_pcwe_cycle"}, 64'(pc_it), 64'(v.exp_lat));
  endtask

  initial begin
    vec_t r;
    int bad;
    rst = 1'b1; ic_step = IC_IDLE; pc_in = '0; flags_in = '0; sp_in = '0;
    mem_busy = 1'b0; ld_req = 1'b0; ld_hi = '0; ld_lo = '0;

    tbl[0] = '{32'h0000_1234, 4'hB, 16'h07FF, 16'h0000, 16'h0100, 4, 4, 0, 0, 1'b0,
               32'h0000_0100, 16'h07FC, 16'h07FF, 16'h07FE, 16'h07FD, 16'h000B, 3, 1, 7, 1'b0};
    tbl[1] = '{32'h0000_1234, 4'hB, 16'h07FF, 16'h0000, 16'h0100, 4, 4, 2, 2, 1'b0,
               32'h0000_0100, 16'h07FC, 16'h07FF, 16'h07FE, 16'h07FD, 16'h000B, 5, 3, 8, 1'b0};
    tbl[2] = '{32'h0000_1234, 4'hB, 16'h07FF, 16'h0000, 16'h0100, 4, 1, 0, 0, 1'b0,
               32'h0000_0100, 16'h07FC, 16'h07FF, 16'h07FE, 16'h07FD, 16'h000B, 3, 1, 6, 1'b0};
    tbl[3] = '{32'hABCD_5678, 4'h5, 16'h0001, 16'h1111, 16'h2222, 0, 4, 0, 0, 1'b0,
               32'h5678_ABCD, 16'hFFFE, 16'h0001, 16'h0000, 16'hFFFF, 16'h0005, 3, 1, 7, 1'b0};
    tbl[4] = '{32'h1234_5678, 4'h3, 16'h0000, 16'h4444, 16'h00AA, 1, 4, 0, 0, 1'b0,
               32'h1234_00AA, 16'hFFFD, 16'h0000, 16'hFFFF, 16'hFFFE, 16'h0003, 3, 1, 7, 1'b0};
    tbl[5] = '{32'h0000_4321, 4'hF, 16'h1000, 16'hDEAD, 16'hBEEF, 2, 6, 0, 0, 1'b1,
               32'hDEAD_BEEF, 16'h0FFD, 16'h1000, 16'h0FFF, 16'h0FFE, 16'h000F, 3, 1, 9, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_ctl", 64'({stall_fetch, mem_we, mem_re, sp_we, pc_we, seq_done, seq_err}), 64'd0);
    check("rst_data", 64'({mem_addr, mem_wdata, sp_out}), 64'd0);
    check("rst_pc_out", 64'(pc_out), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_seq(tbl[i], $sformatf("t%0d", i));

    @(negedge clk);
    check("err_sticky", 64'(seq_err), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("err_cleared", 64'(seq_err), 64'd0);

    // Reset while the low PC word is being pushed.
    @(negedge clk);
    ic_step = IC_SAVE; sp_in = 16'h0400; pc_in = 32'h5555_AAAA; flags_in = 4'h1;
    @(negedge clk);
    ic_step = IC_IDLE;
    @(negedge clk);
    check("midrst_in_pcl", 64'({mem_we, mem_addr, mem_wdata}), {31'd0, 1'b1, 16'h03FF, 16'hAAAA});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ctl", 64'({stall_fetch, mem_we, mem_re, sp_we, pc_we, seq_done, seq_err}), 64'd0);
    check("midrst_data", 64'({mem_addr, mem_wdata, sp_out}), 64'd0);
    check("midrst_pc_out", 64'(pc_out), 64'd0);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (sp_we || pc_we || stall_fetch) bad++;
    end
    check("midrst_quiet", 64'(bad), 64'd0);
    r = tbl[0];
    r.ndrain = 1; r.exp_lat = -1;
    run_seq(r, "after_rst");

    for (int n = 0; n < 20; n++) begin
      r.pc = $urandom; r.flags = 4'($urandom); r.sp = 16'($urandom);
      r.vhi = 16'($urandom); r.vlo = 16'($urandom);
      r.ndrain = $urandom_range(0, 3); r.vgap = $urandom_range(1, 8);
      r.busy_at = $urandom_range(0, 8); r.busy_len = $urandom_range(1, 3);
      r.illegal = 1'b0;
      r.exp_pc = model_vec(r.sp, r.pc, r.flags, r.vhi, r.vlo);
      r.exp_sp = r.sp - 16'd3;
      r.exp_a0 = r.sp; r.exp_a1 = r.sp - 16'd1; r.exp_a2 = r.sp - 16'd2;
      r.exp_flw = {12'h000, r.flags};
      r.exp_wecyc = -1; r.exp_a1cyc = -1; r.exp_lat = -1; r.exp_err = 1'b0;
      run_seq(r, $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
